// File: rtl/coeff_fetch_seq.sv
// Coefficient fetch sequencer: reads ORDER+1 coefficients of one segment (highest power first)
// and hands them to the MAC over valid/ready. Optional 2-entry prefetch buffer via COEFF_PREFETCH_EN.
module coeff_fetch_seq #(
    parameter int ADDR_LINES = 4,
    parameter int SEG_BITS   = 2,
    parameter int ORDER      = 3,
    parameter int DATA_W     = 16
) (
    input  logic                         clkn_i,
    input  logic                         rstn_i,
    input  logic                         start_i,
    input  logic [SEG_BITS-1:0]          seg_i,
    input  logic                         abort_i,
    output logic                         rd_en_o,
    output logic [ADDR_LINES-1:0]        rd_addr_o,
    input  logic [DATA_W-1:0]            rd_data_i,
    output logic                         coef_valid_o,
    output logic [DATA_W-1:0]            coef_data_o,
    output logic [$clog2(ORDER+1)-1:0]   coef_idx_o,
    output logic                         coef_last_o,
    input  logic                         coef_ready_i,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int K_W = $clog2(ORDER + 1);

    if ((1 << SEG_BITS) * (ORDER + 1) > (1 << ADDR_LINES)) begin : g_cfg_chk
        $error("coeff_fetch_seq: segment table does not fit the address space");
    end

    function automatic logic [ADDR_LINES-1:0] coef_addr(input logic [SEG_BITS-1:0] seg,
                                                        input logic [K_W-1:0] k);
        coef_addr = ADDR_LINES'(seg) * ADDR_LINES'(ORDER + 1) + ADDR_LINES'(k);
    endfunction

`ifdef COEFF_PREFETCH_EN
    logic                    active_r;
    logic                    done_r;
    logic [SEG_BITS-1:0]     seg_r;
    logic [K_W-1:0]          iss_k_r;
    logic [K_W-1:0]          pop_k_r;
    logic                    iss_end_r;
    logic                    cap_r;
    logic [1:0][DATA_W-1:0]  buf_r;
    logic                    wr_ptr_r;
    logic                    rd_ptr_r;
    logic [1:0]              cnt_r;
    logic                    abort_s;
    logic                    start_s;
    logic                    pop_s;
    logic                    issue_s;
    logic [2:0]              occ_s;

    // Issue decision counts buffered entries plus the read whose data lands this cycle, net of a pop
    always_comb begin
        abort_s = abort_i && (active_r || done_r);
        start_s = start_i && !abort_i && !active_r && !done_r;
        pop_s   = (cnt_r != 2'd0) && coef_ready_i;
        occ_s   = {1'b0, cnt_r} + {2'b00, cap_r} - {2'b00, pop_s};
        issue_s = active_r && !iss_end_r && !abort_i && (occ_s < 3'd2);
    end

    // Buffer, issue and pop bookkeeping
    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            active_r  <= 1'b0;
            done_r    <= 1'b0;
            seg_r     <= '0;
            iss_k_r   <= K_W'(ORDER);
            pop_k_r   <= K_W'(ORDER);
            iss_end_r <= 1'b0;
            cap_r     <= 1'b0;
            buf_r     <= '0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            cnt_r     <= 2'd0;
        end else if (abort_s) begin
            active_r  <= 1'b0;
            done_r    <= 1'b0;
            cap_r     <= 1'b0;
            cnt_r     <= 2'd0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
        end else if (start_s) begin
            active_r  <= 1'b1;
            done_r    <= 1'b0;
            seg_r     <= seg_i;
            iss_k_r   <= K_W'(ORDER);
            pop_k_r   <= K_W'(ORDER);
            iss_end_r <= 1'b0;
            cap_r     <= 1'b0;
            cnt_r     <= 2'd0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
        end else begin
            cap_r <= issue_s;
            if (issue_s) begin
                if (iss_k_r == K_W'(0)) iss_end_r <= 1'b1;
                else                    iss_k_r   <= iss_k_r - K_W'(1);
            end
            if (cap_r) begin
                buf_r[wr_ptr_r] <= rd_data_i;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
                if (pop_k_r == K_W'(0)) active_r <= 1'b0;
                else                    pop_k_r  <= pop_k_r - K_W'(1);
            end
            done_r <= pop_s && (pop_k_r == K_W'(0));
            cnt_r  <= cnt_r + 2'(cap_r) - 2'(pop_s);
        end
    end

    assign rd_en_o      = issue_s;
    assign rd_addr_o    = issue_s ? coef_addr(seg_r, iss_k_r) : '0;
    assign coef_valid_o = (cnt_r != 2'd0);
    assign coef_data_o  = coef_valid_o ? buf_r[rd_ptr_r] : '0;
    assign coef_idx_o   = coef_valid_o ? pop_k_r : '0;
    assign coef_last_o  = coef_valid_o && (pop_k_r == K_W'(0));
    assign busy_o       = active_r || done_r;
    assign done_o       = done_r;
`else
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_CAPT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]           state_r, state_s;
    logic [K_W-1:0]       k_r, k_s;
    logic [SEG_BITS-1:0]  seg_r, seg_s;
    logic                 rd_en_r;
    logic [ADDR_LINES-1:0] rd_addr_r;
    logic                 coef_valid_r;
    logic [DATA_W-1:0]    coef_data_r;
    logic [K_W-1:0]       coef_idx_r;
    logic                 coef_last_r;
    logic                 busy_r;
    logic                 done_r;

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        seg_s   = seg_r;
        if ((state_r != ST_IDLE) && abort_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_s = ST_FETCH;
                        k_s     = K_W'(ORDER);
                        seg_s   = seg_i;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FETCH: state_s = ST_CAPT;
                ST_CAPT:  state_s = ST_HOLD;
                ST_HOLD: begin
                    if (coef_ready_i && (k_r != K_W'(0))) begin
                        state_s = ST_FETCH;
                        k_s     = k_r - K_W'(1);
                    end else if (coef_ready_i) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_DONE:  state_s = ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // State plus outputs registered from the next state so they line up with it
    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r      <= ST_IDLE;
            k_r          <= K_W'(ORDER);
            seg_r        <= '0;
            rd_en_r      <= 1'b0;
            rd_addr_r    <= '0;
            coef_valid_r <= 1'b0;
            coef_data_r  <= '0;
            coef_idx_r   <= '0;
            coef_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            k_r          <= k_s;
            seg_r        <= seg_s;
            rd_en_r      <= (state_s == ST_FETCH);
            rd_addr_r    <= (state_s == ST_FETCH) ? coef_addr(seg_s, k_s) : '0;
            if ((state_r == ST_CAPT) && !abort_i) coef_data_r <= rd_data_i;
            coef_valid_r <= (state_s == ST_HOLD);
            coef_idx_r   <= (state_s == ST_HOLD) ? k_s : '0;
            coef_last_r  <= (state_s == ST_HOLD) && (k_s == K_W'(0));
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= (state_s == ST_DONE);
        end
    end

    assign rd_en_o      = rd_en_r;
    assign rd_addr_o    = rd_addr_r;
    assign coef_valid_o = coef_valid_r;
    assign coef_data_o  = coef_data_r;
    assign coef_idx_o   = coef_idx_r;
    assign coef_last_o  = coef_last_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
`endif
endmodule
